sya_psum_pack: RTL and testbench

Systolic-array psum drain controller. Round-robin arbitrates requantized psum streams from NUM_ROW PE rows, packs PACK_NUM accepted values into one global-buffer word, and issues sequential write requests from a configured base address. Signals layer completion to the CCU. Sits between the PE_ROW outputs of the SYA and the global buffer write port.

---
 rtl/sya_psum_pack_if.sv | 25 ++
 rtl/sya_psum_pack.sv | 170 +++++++++++++++++
 tb/tb_sya_psum_pack.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sya_psum_pack_if.sv
// Psum drain and global-buffer write bus between the SYA PE rows and the buffer.
// master = the drain controller, slave = rows/buffer side.
interface sya_psum_pack_if #(
    parameter int ACT_WIDTH  = 8,
    parameter int NUM_ROW    = 16,
    parameter int PACK_NUM   = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [NUM_ROW-1:0]            InPsumVld;
    logic [ACT_WIDTH*NUM_ROW-1:0]  InPsum;
    logic [NUM_ROW-1:0]            OutPsumRdy;
    logic                          OutWrVld;
    logic [ADDR_WIDTH-1:0]         OutWrAddr;
    logic [ACT_WIDTH*PACK_NUM-1:0] OutWrDat;
    logic                          InWrRdy;

    modport master (
        input  InPsumVld, InPsum, InWrRdy,
        output OutPsumRdy, OutWrVld, OutWrAddr, OutWrDat
    );
    modport slave (
        output InPsumVld, InPsum, InWrRdy,
        input  OutPsumRdy, OutWrVld, OutWrAddr, OutWrDat
    );
endinterface

// File: rtl/sya_psum_pack.sv
// Systolic-array psum drain: round-robin row arbitration, PACK_NUM-lane word packing, sequential buffer writes.
// Optional SYA_PSUM_PARTIAL_FLUSH_EN adds CCUSYA_Flush to push out a partially packed word.
module sya_psum_pack_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module sya_psum_pack #(
    parameter int ACT_WIDTH  = 8,
    parameter int NUM_ROW    = 16,
    parameter int PACK_NUM   = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUSYA_Rst,
    input  logic                  CCUSYA_Start,
    input  logic [ADDR_WIDTH-1:0] CCUSYA_CfgBaseAddr,
    input  logic [ADDR_WIDTH-1:0] CCUSYA_CfgNumWord,
`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
    input  logic                  CCUSYA_Flush,
`endif
    sya_psum_pack_if.master       bus,
    output logic                  OutDone
);
    localparam int PTR_W  = (NUM_ROW  > 1) ? $clog2(NUM_ROW)  : 1;
    localparam int PCNT_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PACK  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ADDR_WIDTH-1:0] cnt;
        logic [ADDR_WIDTH-1:0] num;
    } wrSeq_t;

    logic [1:0]                         state;
    logic [PTR_W-1:0]                   ptr;
    logic [PCNT_W-1:0]                  packCnt;
    wrSeq_t                             wrSeq;
    logic [NUM_ROW-1:0][ACT_WIDTH-1:0]  psumArr;
    logic [PACK_NUM-1:0][ACT_WIDTH-1:0] laneQ;
    logic [PACK_NUM-1:0]                laneWe;

    logic [NUM_ROW-1:0] grant;
    logic [PTR_W-1:0]   gntIdx;
    logic               gntAny;
    logic [PTR_W:0]     rSum;
    logic [PTR_W-1:0]   rIdx;

    assign psumArr = bus.InPsum;

    // Rotating priority search beginning at the row after the last winner.
    always_comb begin
        grant  = '0;
        gntIdx = '0;
        gntAny = 1'b0;
        rSum   = '0;
        rIdx   = '0;
        for (int i = 0; i < NUM_ROW; i++) begin
            rSum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (rSum >= (PTR_W+1)'(NUM_ROW)) rSum = rSum - (PTR_W+1)'(NUM_ROW);
            rIdx = rSum[PTR_W-1:0];
            if (!gntAny && bus.InPsumVld[rIdx]) begin
                gntAny = 1'b1;
                gntIdx = rIdx;
            end
        end
        if (state != PACK) gntAny = 1'b0;
        if (gntAny) grant[gntIdx] = 1'b1;
    end

    logic             xfer, lastLane, flushHit, wordDone, wrAcc, lastWord, startHit, laneClr;
    logic [PTR_W-1:0] ptrNxt;

    assign xfer     = gntAny;
    assign lastLane = (packCnt == PCNT_W'(PACK_NUM-1));
`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
    assign flushHit = (state == PACK) && (packCnt != '0) && CCUSYA_Flush && !(xfer && lastLane);
`else
    assign flushHit = 1'b0;
`endif
    assign wordDone = (xfer && lastLane) || flushHit;
    assign wrAcc    = (state == WRITE) && bus.InWrRdy;
    assign lastWord = (wrSeq.cnt == wrSeq.num - 1'b1);
    assign startHit = CCUSYA_Start && ((state == IDLE) || (state == DONE));
    assign ptrNxt   = (gntIdx == PTR_W'(NUM_ROW-1)) ? '0 : gntIdx + 1'b1;
    // Lanes are zeroed whenever a fresh word begins, so unfilled lanes read as zero.
    assign laneClr  = CCUSYA_Rst || startHit || (wrAcc && !lastWord);

    genvar gi;
    generate
        for (gi = 0; gi < PACK_NUM; gi++) begin : gLane
            assign laneWe[gi] = !CCUSYA_Rst && xfer && (packCnt == PCNT_W'(gi));
            sya_psum_pack_lane #(.W(ACT_WIDTH)) uLane (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (laneClr),
                .we    (laneWe[gi]),
                .d     (psumArr[gntIdx]),
                .q     (laneQ[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            packCnt <= '0;
            wrSeq   <= '0;
        end else if (CCUSYA_Rst) begin
            state     <= IDLE;
            ptr       <= '0;
            packCnt   <= '0;
            wrSeq.cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (CCUSYA_Start) begin
                        wrSeq.addr <= CCUSYA_CfgBaseAddr;
                        wrSeq.num  <= CCUSYA_CfgNumWord;
                        wrSeq.cnt  <= '0;
                        packCnt    <= '0;
                        state      <= (CCUSYA_CfgNumWord == '0) ? DONE : PACK;
                    end
                end
                PACK: begin
                    if (xfer) begin
                        ptr     <= ptrNxt;
                        packCnt <= packCnt + 1'b1;
                    end
                    if (wordDone) begin
                        packCnt <= '0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.InWrRdy) begin
                        wrSeq.addr <= wrSeq.addr + 1'b1;
                        wrSeq.cnt  <= wrSeq.cnt + 1'b1;
                        state      <= lastWord ? DONE : PACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.OutPsumRdy = grant;
    assign bus.OutWrVld   = (state == WRITE);
    assign bus.OutWrAddr  = wrSeq.addr;
    assign bus.OutWrDat   = laneQ;
    assign OutDone        = (state == DONE);
endmodule

// File: tb/tb_sya_psum_pack.sv
// Bench for sya_psum_pack: directed scenarios plus randomized layers against a queue-based reference model.
module tb_sya_psum_pack;
    localparam int AW = 8, NR = 4, PN = 4, ADW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            ccuRst, start, done, flush;
    logic [ADW-1:0]  base, numw;

    sya_psum_pack_if #(.ACT_WIDTH(AW), .NUM_ROW(NR), .PACK_NUM(PN), .ADDR_WIDTH(ADW)) bus ();

    sya_psum_pack #(.ACT_WIDTH(AW), .NUM_ROW(NR), .PACK_NUM(PN), .ADDR_WIDTH(ADW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .CCUSYA_Rst         (ccuRst),
        .CCUSYA_Start       (start),
        .CCUSYA_CfgBaseAddr (base),
        .CCUSYA_CfgNumWord  (numw),
`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
        .CCUSYA_Flush       (flush),
`endif
        .bus                (bus),
        .OutDone            (done)
    );

    int vectors = 0, miscompares = 0;

    // reference model: a layer is "busy" until its words are written, a word is "pending" while awaiting the buffer
    bit   mBusy = 0, mPend = 0, mDone = 0;
    int   mPtr = 0, mAddr = 0, mLeft = 0;
    logic [7:0]  mLanes[$];
    logic [31:0] mWord = '0;
    logic [15:0] logAddr[$];
    logic [31:0] logDat[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int expGrant();
        for (int k = 0; k < NR; k++) begin
            int r;
            r = (mPtr + k) % NR;
            if (bus.InPsumVld[r]) return r;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        bit hadLanes;
        logic [31:0] w;
        #1;
        g = (mBusy && !mPend) ? expGrant() : -1;
        chk("psum_rdy", 64'(bus.OutPsumRdy), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("wr_vld", 64'(bus.OutWrVld), 64'(mPend));
        chk("done", 64'(done), 64'(mDone));
        if (mPend) begin
            chk("wr_addr", 64'(bus.OutWrAddr), 64'(mAddr));
            chk("wr_dat", 64'(bus.OutWrDat), 64'(mWord));
        end
        if (bus.OutWrVld && bus.InWrRdy) begin
            logAddr.push_back(bus.OutWrAddr);
            logDat.push_back(bus.OutWrDat);
        end
        if (ccuRst) begin
            mBusy = 0; mPend = 0; mDone = 0; mPtr = 0;
            mLanes.delete();
        end else if (!mBusy) begin
            if (start) begin
                mAddr = int'(base); mLeft = int'(numw);
                mLanes.delete();
                mDone = (numw == 0);
                mBusy = (numw != 0);
            end
        end else if (!mPend) begin
            hadLanes = (mLanes.size() > 0);
            if (g >= 0) begin
                mLanes.push_back(bus.InPsum[g*AW +: AW]);
                mPtr = (g + 1) % NR;
            end
`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
            if (flush && hadLanes && mLanes.size() < PN) begin
                for (int k = mLanes.size(); k < PN; k++) mLanes.push_back(8'h00);
            end
`else
            hadLanes = 0;
`endif
            if (mLanes.size() == PN) begin
                w = '0;
                for (int k = 0; k < PN; k++) w |= 32'(mLanes[k]) << (8*k);
                mWord = w;
                mLanes.delete();
                mPend = 1;
            end
        end else if (bus.InWrRdy) begin
            mPend = 0;
            mAddr = (mAddr + 1) % 65536;
            mLeft--;
            if (mLeft == 0) begin mBusy = 0; mDone = 1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setRows(input logic [3:0] m, input logic [7:0] off);
        bus.InPsumVld = m;
        for (int r = 0; r < NR; r++) bus.InPsum[r*AW +: AW] = off + 8'(r);
    endtask

    task automatic pulseStart(input logic [15:0] b, input logic [15:0] n);
        base = b; numw = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic runLayer(input int budget, input bit rnd);
        int n = 0;
        while (!mDone && n < budget) begin
            if (rnd) begin
                bus.InPsumVld = 4'($urandom);
                bus.InPsum    = $urandom;
                bus.InWrRdy   = ($urandom_range(0, 3) != 0);
                base          = 16'($urandom);
                numw          = 16'($urandom);
`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
                flush         = ($urandom_range(0, 7) == 0);
`endif
            end
            step();
            n++;
        end
        chk("layer_done", 64'(done), 64'd1);
    endtask

    initial begin
        ccuRst = 0; start = 0; base = 0; numw = 0; flush = 0;
        bus.InPsumVld = '0; bus.InPsum = '0; bus.InWrRdy = 1'b1;
        #12;
        chk("rst_rdy", 64'(bus.OutPsumRdy), 64'd0);
        chk("rst_vld", 64'(bus.OutWrVld), 64'd0);
        chk("rst_addr", 64'(bus.OutWrAddr), 64'd0);
        chk("rst_dat", 64'(bus.OutWrDat), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all rows valid, psum = row index
        setRows(4'hF, 8'h00);
        pulseStart(16'h0010, 16'd2);
        runLayer(50, 0);
        chk("s1_w0", {logAddr[0], logDat[0]}, {16'h0010, 32'h03020100});
        chk("s1_w1", {logAddr[1], logDat[1]}, {16'h0011, 32'h03020100});
        logAddr.delete(); logDat.delete();

        // rows 1 and 3 only
        setRows(4'b1010, 8'h00);
        pulseStart(16'h0040, 16'd1);
        runLayer(50, 0);
        chk("s2_w0", {logAddr[0], logDat[0]}, {16'h0040, 32'h03010301});
        logAddr.delete(); logDat.delete();

        // buffer stalls the write
        setRows(4'hF, 8'h10);
        bus.InWrRdy = 1'b0;
        pulseStart(16'h0050, 16'd1);
        for (int i = 0; i < 10; i++) step();
        bus.InWrRdy = 1'b1;
        runLayer(50, 0);
        chk("s3_w0", {logAddr[0], logDat[0]}, {16'h0050, 32'h13121110});
        logAddr.delete(); logDat.delete();

        // sync clear mid-word, then a fresh layer
        pulseStart(16'h0030, 16'd1);
        step(); step();
        ccuRst = 1'b1;
        step();
        ccuRst = 1'b0;
        chk("s4_vld", 64'(bus.OutWrVld), 64'd0);
        setRows(4'hF, 8'h40);
        pulseStart(16'h0020, 16'd1);
        runLayer(50, 0);
        chk("s4_w0", {logAddr[0], logDat[0]}, {16'h0020, 32'h43424140});
        logAddr.delete(); logDat.delete();

        // empty layer, then address wrap
        pulseStart(16'h0099, 16'd0);
        chk("s5_done", 64'(done), 64'd1);
        step();
        setRows(4'hF, 8'h00);
        pulseStart(16'hFFFF, 16'd2);
        runLayer(50, 0);
        chk("s5_a0", 64'(logAddr[0]), 64'hFFFF);
        chk("s5_a1", 64'(logAddr[1]), 64'h0000);
        logAddr.delete(); logDat.delete();

`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
        bus.InPsumVld = 4'b0001;
        pulseStart(16'h0060, 16'd2);
        bus.InPsum[7:0] = 8'hAA; step();
        bus.InPsum[7:0] = 8'hBB; step();
        bus.InPsum[7:0] = 8'hCC; step();
        bus.InPsumVld = 4'b0000; flush = 1'b1; step();
        flush = 1'b0;
        chk("s6_dat", 64'(bus.OutWrDat), 64'h00CCBBAA);
        setRows(4'hF, 8'h00);
        runLayer(50, 0);
        chk("s6_w0", {logAddr[0], logDat[0]}, {16'h0060, 32'h00CCBBAA});
        logAddr.delete(); logDat.delete();
`endif

        for (int l = 0; l < 20; l++) begin
            bus.InPsumVld = '0;
            pulseStart(16'($urandom), 16'($urandom_range(1, 4)));
            runLayer(600, 1);
`ifdef SYA_PSUM_PARTIAL_FLUSH_EN
            flush = 1'b0;
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
